// File: rtl/qd2_pkg.sv
// Shared definitions for the serial address path: widths, synchronizer depth
// and the address loader's FSM encoding.
package qd2_pkg;

    localparam int ADDR_W      = 21;
    localparam int BITCNT_W    = 5;
    localparam int SYNC_STAGES = 2;

    // Cycles after reset before the synchronizer and history flops all hold real pin values.
    localparam int WARM_CYCLES = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync2.sv
// Multi-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so each pin can reset to its own idle level.
module sync2
    import qd2_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/addr_loader.sv
// Address-load stage: counts synchronized sclk edges inside a cs_n frame and commits
// the shift-register word only for exact-length frames; auto-increments between loads.
module addr_loader
    import qd2_pkg::*;
#(
    parameter int DWIDTH = ADDR_W,
    parameter int CNT_W  = BITCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [DWIDTH-1:0] sreg_q,
    input  logic              inc,
    output logic [DWIDTH-1:0] addr,
    output logic              addr_valid,
    output logic              addr_load,
    output logic              frame_err,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DWIDTH);
    localparam logic [1:0]       WARM_MAX = 2'(WARM_CYCLES);

    // Handshake: inc is a single-cycle request, acted on at the next clk edge when
    // addr_valid is set; a commit-load in the same cycle takes priority and the
    // request is dropped. addr_load/frame_err are one-cycle registered pulses.

    logic sclk_s, cs_s;
    logic sclk_h, cs_h;
    logic [1:0] warm_cnt;
    logic warm;
    logic sclk_rise, cs_fall, cs_rise;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_d, err_d;

    sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (cs_s)
    );

    // Edges are masked until the reset values have flushed out of the pipeline, so a
    // frame already in progress at reset release never looks like a fresh cs_n fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_h   <= 1'b0;
            cs_h     <= 1'b1;
            warm_cnt <= '0;
        end else begin
            sclk_h <= sclk_s;
            cs_h   <= cs_s;
            if (!warm) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign warm      = (warm_cnt == WARM_MAX);
    assign sclk_rise = warm &  sclk_s & ~sclk_h;
    assign cs_fall   = warm & ~cs_s   &  cs_h;
    assign cs_rise   = warm &  cs_s   & ~cs_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Saturate so an overlong frame can never alias back to an exact count.
                if (sclk_rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cs_rise) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (cnt_q == CNT_FULL) begin
                    load_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            addr_valid <= 1'b0;
            addr_load  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            addr_load <= load_d;
            frame_err <= err_d;
            if (load_d) begin
                addr       <= sreg_q;
                addr_valid <= 1'b1;
            end else if (inc && addr_valid) begin
                addr <= addr + 1'b1;
            end
        end
    end

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule
